// File: rtl/icache_direct_pkg.sv
// Shared constants, FSM encoding and address helpers for the direct-mapped I-cache.
package icache_direct_pkg;

    localparam int unsigned ICACHE_INDEX_W = 7;
    localparam logic [2:0]  KSEG1_TOP      = 3'b101;
    localparam logic [31:0] PADDR_MASK     = 32'h1FFF_FFFF;

    typedef enum logic [2:0] {
        ICACHE_IDLE      = 3'd0,
        ICACHE_MISS_REQ  = 3'd1,
        ICACHE_MISS_WAIT = 3'd2,
        ICACHE_UC_REQ    = 3'd3,
        ICACHE_UC_WAIT   = 3'd4,
        ICACHE_UC_DONE   = 3'd5
    } icache_state_e;

    // kseg1 fetches never touch the arrays
    function automatic logic is_uncached(input logic [31:0] vaddr);
        return vaddr[31:29] == KSEG1_TOP;
    endfunction

endpackage

// File: rtl/icache_tagv.sv
// Valid/tag array with the hit compare; valid bits clear on reset, tags do not.
module icache_tagv
    import icache_direct_pkg::*;
#(
    parameter int unsigned INDEX_W = ICACHE_INDEX_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [INDEX_W-1:0]   rd_index_i,
    input  logic [27-INDEX_W:0]  rd_tag_i,
    output logic                 hit_o,
    input  logic                 wr_en_i,
    input  logic [INDEX_W-1:0]   wr_index_i,
    input  logic [27-INDEX_W:0]  wr_tag_i
);

    localparam int unsigned Lines = 2 ** INDEX_W;
    localparam int unsigned TagW  = 28 - INDEX_W;

    logic [Lines-1:0] valid_q, valid_d;
    logic [TagW-1:0]  tag_q [Lines];

    // Next-state of the valid vector: a completed refill marks its line valid
    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_index_i] = 1'b1;
        end
    end

    // Valid register, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag storage, written once per completed refill
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    // Lookup compare
    always_comb begin
        hit_o = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with 4-word line refill and kseg1 bypass
// over a single-outstanding SRAM-like port.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int unsigned INDEX_W    = ICACHE_INDEX_W,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        inst_stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam int unsigned Lines = 2 ** INDEX_W;
    localparam int unsigned CntW  = $clog2(LINE_WORDS);
    localparam int unsigned TagW  = 28 - INDEX_W;

    icache_state_e state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]   uc_buf_q, uc_buf_d;

    logic [31:0] data_q [Lines][LINE_WORDS];

    logic [31:0]        paddr;
    logic               uncached;
    logic [INDEX_W-1:0] req_index;
    logic [TagW-1:0]    req_tag;
    logic [CntW-1:0]    req_word;
    logic [INDEX_W-1:0] line_index;
    logic [TagW-1:0]    line_tag;
    logic               tag_hit;
    logic               data_we;
    logic               tag_we;

    // Address decode of the incoming fetch and of the latched miss address
    always_comb begin
        paddr      = cpu_addr & PADDR_MASK;
        uncached   = is_uncached(cpu_addr);
        req_index  = paddr[3+INDEX_W:4];
        req_tag    = paddr[31:4+INDEX_W];
        req_word   = paddr[3:2];
        line_index = addr_q[3+INDEX_W:4];
        line_tag   = addr_q[31:4+INDEX_W];
    end

    icache_tagv #(
        .INDEX_W (INDEX_W)
    ) u_tagv (
        .clk_i      (clk),
        .rst_ni     (rst),
        .rd_index_i (req_index),
        .rd_tag_i   (req_tag),
        .hit_o      (tag_hit),
        .wr_en_i    (tag_we),
        .wr_index_i (line_index),
        .wr_tag_i   (line_tag)
    );

    // Next-state and port outputs; every refill runs to completion before a new lookup
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        uc_buf_d   = uc_buf_q;
        cpu_rdata  = '0;
        inst_stall = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        unique case (state_q)
            ICACHE_IDLE: begin
                if (cpu_req) begin
                    if (uncached) begin
                        inst_stall = 1'b1;
                        addr_d     = paddr;
                        state_d    = ICACHE_UC_REQ;
                    end else if (tag_hit) begin
                        cpu_rdata = data_q[req_index][req_word];
                    end else begin
                        inst_stall = 1'b1;
                        addr_d     = paddr;
                        cnt_d      = '0;
                        state_d    = ICACHE_MISS_REQ;
                    end
                end
            end
            ICACHE_MISS_REQ: begin
                inst_stall = cpu_req;
                inst_req   = 1'b1;
                inst_addr  = {addr_q[31:4], cnt_q, 2'b00};
                if (inst_addr_ok) begin
                    state_d = ICACHE_MISS_WAIT;
                end
            end
            ICACHE_MISS_WAIT: begin
                inst_stall = cpu_req;
                if (inst_data_ok) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CntW'(LINE_WORDS - 1)) begin
                        tag_we  = 1'b1;
                        state_d = ICACHE_IDLE;
                    end else begin
                        state_d = ICACHE_MISS_REQ;
                    end
                end
            end
            ICACHE_UC_REQ: begin
                inst_stall = cpu_req;
                inst_req   = 1'b1;
                inst_addr  = addr_q;
                if (inst_addr_ok) begin
                    state_d = ICACHE_UC_WAIT;
                end
            end
            ICACHE_UC_WAIT: begin
                inst_stall = cpu_req;
                if (inst_data_ok) begin
                    uc_buf_d = inst_rdata;
                    state_d  = ICACHE_UC_DONE;
                end
            end
            ICACHE_UC_DONE: begin
                // Buffered word only goes to the fetch that asked for it
                if (paddr != addr_q) begin
                    inst_stall = cpu_req;
                    state_d    = ICACHE_IDLE;
                end else if (cpu_req) begin
                    cpu_rdata = uc_buf_q;
                    state_d   = ICACHE_IDLE;
                end
            end
            default: begin
                state_d = ICACHE_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ICACHE_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            uc_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            uc_buf_q <= uc_buf_d;
        end
    end

    // Data array write port, one word per refill beat
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[line_index][cnt_q] <= inst_rdata;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench: SRAM-like slave with random latency, cache-content reference model.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        inst_stall;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    int checks = 0;
    int errors = 0;
    int max_lat = 0;
    logic [31:0] acc_q[$];

    // Reference model: which line holds which tag (2^7 lines, 21-bit tags)
    bit          m_valid [128];
    logic [20:0] m_tag   [128];

    icache_direct #(
        .INDEX_W    (7),
        .LINE_WORDS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_rdata    (cpu_rdata),
        .inst_stall   (inst_stall),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing memory contents as a fixed function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000 ^ a;
    endfunction

    function automatic bit is_unc(input logic [31:0] va);
        return va[31:29] == 3'b101;
    endfunction

    function automatic bit model_hit(input logic [31:0] va);
        logic [31:0] pa;
        pa = va & 32'h1FFF_FFFF;
        return !is_unc(va) && m_valid[pa[10:4]] && (m_tag[pa[10:4]] == pa[31:11]);
    endfunction

    task automatic model_fill(input logic [31:0] va);
        logic [31:0] pa;
        pa = va & 32'h1FFF_FFFF;
        m_valid[pa[10:4]] = 1'b1;
        m_tag[pa[10:4]]   = pa[31:11];
    endtask

    // SRAM-like slave: addr_ok after 0..max_lat cycles, data_ok 1..max_lat+1 cycles later
    initial begin : slave
        bit          pend;
        int          data_wait;
        int          addr_wait;
        logic [31:0] pend_addr;
        pend         = 1'b0;
        data_wait    = 0;
        addr_wait    = -1;
        pend_addr    = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        forever begin
            @(posedge clk);
            #2;
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            if (!rst) begin
                pend      = 1'b0;
                addr_wait = -1;
            end else begin
                if (pend) begin
                    if (data_wait == 0) begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = mem_word(pend_addr);
                        pend         = 1'b0;
                    end else begin
                        data_wait--;
                    end
                end
                if (inst_req && !pend) begin
                    if (addr_wait < 0) addr_wait = int'($urandom_range(max_lat, 0));
                    if (addr_wait == 0) begin
                        inst_addr_ok = 1'b1;
                        pend         = 1'b1;
                        pend_addr    = inst_addr;
                        data_wait    = int'($urandom_range(max_lat, 0));
                        addr_wait    = -1;
                        acc_q.push_back(inst_addr);
                    end else begin
                        addr_wait--;
                    end
                end
            end
        end
    end

    // Request must hold with a stable address until accepted
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                check("req_held", {31'b0, inst_req}, 32'd1);
                check("addr_stable", inst_addr, prev_addr);
            end
            prev_hold <= inst_req && !inst_addr_ok;
            prev_addr <= inst_addr;
        end
    end

    // Present one fetch and hold it until served; returns stall cycles, ends on the served negedge
    task automatic fetch(input logic [31:0] va, output int stalls);
        logic [31:0] pa;
        bit          done;
        pa     = va & 32'h1FFF_FFFF;
        done   = 1'b0;
        stalls = 0;
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = va;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!inst_stall) begin
                check("fetch_rdata", cpu_rdata, mem_word(pa));
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!done) check("fetch_timeout", 32'd0, 32'd1);
        if (!is_unc(va)) model_fill(va);
    endtask

    // Fetch with expectation from the model: exact stall count with a zero-wait slave
    task automatic run_fetch(input logic [31:0] va, input string name);
        int st;
        bit mh;
        int exp_st;
        mh     = model_hit(va);
        exp_st = mh ? 0 : (is_unc(va) ? 3 : 9);
        fetch(va, st);
        if (max_lat == 0) check({name, "_stalls"}, 32'(st), 32'(exp_st));
        else check({name, "_hit"}, {31'b0, st == 0}, {31'b0, mh});
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          st;
        bit          done;
        bit          redirected;
        logic [31:0] pa;
        logic [31:0] va;
        logic [31:0] exp_acc[8];

        rst      = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        #12;
        check("rst_inst_req", {31'b0, inst_req}, 32'd0);
        check("rst_inst_addr", inst_addr, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_stall_noreq", {31'b0, inst_stall}, 32'd0);
        cpu_req  = 1'b1;
        cpu_addr = 32'h9FC0_0010;
        #1;
        check("rst_stall_req", {31'b0, inst_stall}, 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Cold miss: 9 stall cycles, refill words 0..3 in order
        acc_q.delete();
        run_fetch(32'h9FC0_0010, "cold");
        check("cold_acc_n", acc_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++)
            check("cold_acc_addr", acc_q[i], 32'h1FC0_0010 + 32'(i * 4));

        // Hit after fill: same-cycle data, no request
        run_fetch(32'h9FC0_001C, "hit");
        check("hit_no_req", {31'b0, inst_req}, 32'd0);

        // Conflict eviction on the same index
        run_fetch(32'h9FC0_0810, "evict");
        run_fetch(32'h9FC0_0010, "refetch");

        // Uncached twice: one request each, arrays untouched
        for (int k = 0; k < 2; k++) begin
            acc_q.delete();
            run_fetch(32'hBFC0_0000, "uncached");
            check("uc_acc_n", acc_q.size(), 32'd1);
            if (acc_q.size() > 0) check("uc_acc_addr", acc_q[0], 32'h1FC0_0000);
        end

        // Redirect after the second addr_ok: old line completes, then new line refills
        acc_q.delete();
        st         = 0;
        done       = 1'b0;
        redirected = 1'b0;
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h9FC0_0000;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!inst_stall) begin
                done = 1'b1;
                check("redir_rdata", cpu_rdata, mem_word(32'h1FC0_0380));
            end else begin
                st++;
                @(posedge clk);
                #1;
                if (!redirected && acc_q.size() >= 2) begin
                    cpu_addr   = 32'h9FC0_0380;
                    redirected = 1'b1;
                end
            end
        end
        check("redir_done", {31'b0, done & redirected}, 32'd1);
        check("redir_stalls", 32'(st), 32'd18);
        check("redir_acc_n", acc_q.size(), 32'd8);
        for (int i = 0; i < 4; i++) begin
            exp_acc[i]     = 32'h1FC0_0000 + 32'(i * 4);
            exp_acc[i + 4] = 32'h1FC0_0380 + 32'(i * 4);
        end
        for (int i = 0; i < 8 && i < acc_q.size(); i++)
            check("redir_acc_addr", acc_q[i], exp_acc[i]);
        model_fill(32'h9FC0_0000);
        model_fill(32'h9FC0_0380);
        run_fetch(32'h9FC0_0004, "redir_old_hit");

        // Random traffic with a random-latency slave
        max_lat = 5;
        for (int n = 0; n < 150; n++) begin
            pa = 32'h1FC0_0000 + 32'($urandom_range(2, 0)) * 32'h800
                 + 32'($urandom_range(3, 0)) * 32'h10 + 32'($urandom_range(3, 0)) * 32'h4;
            va = ($urandom_range(4, 0) == 0) ? (pa | 32'hA000_0000) : (pa | 32'h8000_0000);
            run_fetch(va, "rand");
            if ($urandom_range(7, 0) == 0) begin
                @(posedge clk);
                #1;
                cpu_req = 1'b0;
                @(negedge clk);
                check("idle_stall", {31'b0, inst_stall}, 32'd0);
                check("idle_rdata", cpu_rdata, 32'd0);
            end
        end

        // Reset in the middle of a refill
        max_lat = 2;
        acc_q.delete();
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h9FC0_2040;
        done     = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (acc_q.size() >= 2) done = 1'b1;
        end
        check("mid_rst_reached", {31'b0, done}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, inst_req}, 32'd0);
        check("mid_rst_stall", {31'b0, inst_stall}, 32'd1);
        cpu_req = 1'b0;
        #1;
        check("mid_rst_stall_noreq", {31'b0, inst_stall}, 32'd0);
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst     = 1'b1;
        max_lat = 0;
        run_fetch(32'h9FC0_0010, "post_rst_old");
        run_fetch(32'h9FC0_2040, "post_rst_new");
        run_fetch(32'h9FC0_2044, "post_rst_hit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
